// File: rtl/dac3162_pattern_gen.sv
// dac3162_pattern_gen: dual-channel signed 12-bit sample source (stream/DC/ramp/square) for the DAC3162 driver
module dac3162_pattern_gen #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] dc_ch1,
  input  logic [11:0] dc_ch2,
  input  logic [11:0] ramp_step,
  input  logic [15:0] half_period,
  input  logic        s_valid,
  input  logic [23:0] s_data,
  output logic        s_ready,
  output logic [11:0] DA3162_CH1,
  output logic [11:0] DA3162_CH2,
  output logic        underflow,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} st_t;
  st_t st;
  logic [1:0] md;
  logic [11:0] step, acc;
  logic [15:0] hp, cnt;
  logic ph;
  logic [23:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] fc;
  logic full, push, pop;
  assign full = fc == (AW+1)'(FIFO_DEPTH);
  assign s_ready = (st != IDLE) && (md == 2'd0) && !full;
  assign push = s_valid && s_ready && enable;
  assign pop = (st == RUN) && (md == 2'd0) && enable && (fc != '0);
  always_ff @(posedge clk_in)
    if (push) mem[wp] <= s_data;
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      busy <= 1'b0;
      md <= '0;
      step <= '0;
      hp <= '0;
      acc <= '0;
      cnt <= '0;
      ph <= 1'b0;
      wp <= '0;
      rp <= '0;
      fc <= '0;
      DA3162_CH1 <= '0;
      DA3162_CH2 <= '0;
      underflow <= 1'b0;
    end else begin
      if (st == IDLE || !enable) begin
        wp <= '0;
        rp <= '0;
        fc <= '0;
      end else begin
        wp <= wp + AW'(push);
        rp <= rp + AW'(pop);
        fc <= fc + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (st == IDLE) begin
        DA3162_CH1 <= '0;
        DA3162_CH2 <= '0;
        acc <= '0;
        cnt <= '0;
        ph <= 1'b0;
        if (enable) begin
          md <= mode;
          step <= ramp_step;
          hp <= half_period == 16'd0 ? 16'd1 : half_period;
          underflow <= 1'b0;
          busy <= 1'b1;
          st <= mode == 2'd0 ? PRIME : RUN;
        end
      end else if (!enable) begin
        st <= IDLE;
        busy <= 1'b0;
        DA3162_CH1 <= '0;
        DA3162_CH2 <= '0;
      end else if (st == PRIME) begin
        DA3162_CH1 <= '0;
        DA3162_CH2 <= '0;
        if (fc >= (AW+1)'(FIFO_DEPTH / 2)) st <= RUN;
      end else begin
        case (md)
          2'd0: begin
            DA3162_CH1 <= pop ? mem[rp][23:12] : 12'd0;
            DA3162_CH2 <= pop ? mem[rp][11:0] : 12'd0;
            underflow <= underflow | !pop;
          end
          2'd1: begin
            DA3162_CH1 <= dc_ch1;
            DA3162_CH2 <= dc_ch2;
          end
          2'd2: begin
            DA3162_CH1 <= acc;
            DA3162_CH2 <= ~acc;
            acc <= acc + step;
          end
          default: begin
            DA3162_CH1 <= ph ? 12'h800 : 12'h7FF;
            DA3162_CH2 <= ph ? 12'h7FF : 12'h800;
            cnt <= cnt == hp - 16'd1 ? 16'd0 : cnt + 16'd1;
            ph <= cnt == hp - 16'd1 ? ~ph : ph;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dac3162_pattern_gen.sv
// tb_dac3162_pattern_gen: randomized self-checking bench with a sample-sequence reference model
module tb_dac3162_pattern_gen;
  logic clk_in = 1'b0;
  logic rst, enable, s_valid, s_ready, underflow, busy;
  logic [1:0] mode;
  logic [11:0] dc_ch1, dc_ch2, ramp_step, DA3162_CH1, DA3162_CH2;
  logic [15:0] half_period;
  logic [23:0] s_data;
  int tests = 0;
  int fails = 0;

  dac3162_pattern_gen #(.FIFO_DEPTH(16)) dut (
    .clk_in(clk_in), .rst(rst), .enable(enable), .mode(mode),
    .dc_ch1(dc_ch1), .dc_ch2(dc_ch2), .ramp_step(ramp_step), .half_period(half_period),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .DA3162_CH1(DA3162_CH1), .DA3162_CH2(DA3162_CH2), .underflow(underflow), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; dc_ch1 = '0; dc_ch2 = '0;
    ramp_step = '0; half_period = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    tests++;
    if ({DA3162_CH1, DA3162_CH2} !== 24'd0) begin fails++; $display("FAIL reset_out got %h exp 0", {DA3162_CH1, DA3162_CH2}); end
    tests++;
    if ({busy, s_ready, underflow} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {busy, s_ready, underflow}); end
  endtask

  task automatic test_dc;
    logic [11:0] e1, e2;
    @(negedge clk_in);
    mode = 2'd1; dc_ch1 = 12'h123; dc_ch2 = 12'hE00; enable = 1'b1;
    @(negedge clk_in);
    tests++;
    if (busy !== 1'b1 || {DA3162_CH1, DA3162_CH2} !== 24'd0) begin fails++; $display("FAIL dc_start busy=%b out=%h exp busy=1 out=0", busy, {DA3162_CH1, DA3162_CH2}); end
    for (int i = 0; i < 12; i++) begin
      e1 = dc_ch1; e2 = dc_ch2;
      @(negedge clk_in);
      tests++;
      if (DA3162_CH1 !== e1 || DA3162_CH2 !== e2) begin fails++; $display("FAIL dc_out i=%0d got %h/%h exp %h/%h", i, DA3162_CH1, DA3162_CH2, e1, e2); end
      dc_ch1 = 12'($urandom); dc_ch2 = 12'($urandom); mode = 2'($urandom);
    end
    enable = 1'b0;
    @(negedge clk_in);
    tests++;
    if ({DA3162_CH1, DA3162_CH2} !== 24'd0 || busy !== 1'b0) begin fails++; $display("FAIL dc_stop out=%h busy=%b exp 0/0", {DA3162_CH1, DA3162_CH2}, busy); end
  endtask

  task automatic test_ramp(input logic [11:0] step, input int n);
    logic [11:0] e;
    @(negedge clk_in);
    mode = 2'd2; ramp_step = step; enable = 1'b1;
    @(negedge clk_in);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL ramp_busy got %b exp 1", busy); end
    for (int i = 0; i < n; i++) begin
      ramp_step = 12'($urandom); mode = 2'($urandom);
      @(negedge clk_in);
      e = 12'(i * int'(step));
      tests++;
      if (DA3162_CH1 !== e || DA3162_CH2 !== ~e) begin fails++; $display("FAIL ramp_out step=%h i=%0d got %h/%h exp %h/%h", step, i, DA3162_CH1, DA3162_CH2, e, ~e); end
    end
    enable = 1'b0;
    @(negedge clk_in);
    tests++;
    if ({DA3162_CH1, DA3162_CH2} !== 24'd0 || busy !== 1'b0) begin fails++; $display("FAIL ramp_stop out=%h busy=%b exp 0/0", {DA3162_CH1, DA3162_CH2}, busy); end
  endtask

  task automatic test_square(input logic [15:0] hpr, input int n);
    int hpe;
    logic [11:0] e1, e2;
    hpe = hpr == 16'd0 ? 1 : int'(hpr);
    @(negedge clk_in);
    mode = 2'd3; half_period = hpr; enable = 1'b1;
    @(negedge clk_in);
    tests++;
    if (busy !== 1'b1 || {DA3162_CH1, DA3162_CH2} !== 24'd0) begin fails++; $display("FAIL sq_start busy=%b out=%h exp busy=1 out=0", busy, {DA3162_CH1, DA3162_CH2}); end
    for (int i = 0; i < n; i++) begin
      half_period = 16'($urandom); mode = 2'($urandom);
      @(negedge clk_in);
      e1 = ((i / hpe) % 2) == 0 ? 12'h7FF : 12'h800;
      e2 = ((i / hpe) % 2) == 0 ? 12'h800 : 12'h7FF;
      tests++;
      if (DA3162_CH1 !== e1 || DA3162_CH2 !== e2) begin fails++; $display("FAIL sq_out hp=%0d i=%0d got %h/%h exp %h/%h", hpr, i, DA3162_CH1, DA3162_CH2, e1, e2); end
    end
    enable = 1'b0;
    @(negedge clk_in);
    tests++;
    if ({DA3162_CH1, DA3162_CH2} !== 24'd0 || busy !== 1'b0) begin fails++; $display("FAIL sq_stop out=%h busy=%b exp 0/0", {DA3162_CH1, DA3162_CH2}, busy); end
  endtask

  task automatic test_stream(input int n);
    logic [23:0] q[$];
    logic [23:0] eo;
    int mph;
    bit er, acc;
    logic euf;
    mph = 0; euf = 1'b0;
    @(negedge clk_in);
    mode = 2'd0; enable = 1'b1; s_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      s_valid = c < 10 ? 1'b1 : c < 24 ? 1'b0 : c < n - 20 ? 1'($urandom) : 1'b1;
      s_data = 24'($urandom);
      er = (mph != 0) && (q.size() < 16);
      #1;
      tests++;
      if (s_ready !== er) begin fails++; $display("FAIL stream_ready c=%0d got %b exp %b", c, s_ready, er); end
      acc = s_valid && er;
      eo = '0;
      if (mph == 2) begin
        if (q.size() > 0) eo = q.pop_front();
        else euf = 1'b1;
      end
      if (mph == 0) begin mph = 1; euf = 1'b0; end
      else if (mph == 1 && q.size() >= 8) mph = 2;
      if (acc) q.push_back(s_data);
      @(negedge clk_in);
      tests++;
      if ({DA3162_CH1, DA3162_CH2} !== eo || underflow !== euf || busy !== 1'b1) begin
        fails++;
        $display("FAIL stream_out c=%0d got %h uf=%b busy=%b exp %h uf=%b busy=1", c, {DA3162_CH1, DA3162_CH2}, underflow, busy, eo, euf);
      end
    end
    s_valid = 1'b0; enable = 1'b0;
    @(negedge clk_in);
    tests++;
    if ({DA3162_CH1, DA3162_CH2} !== 24'd0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL stream_stop out=%h busy=%b rdy=%b exp 0/0/0", {DA3162_CH1, DA3162_CH2}, busy, s_ready);
    end
  endtask

  task automatic test_reset_run;
    int r;
    r = int'($urandom_range(3, 20));
    @(negedge clk_in);
    mode = 2'd2; ramp_step = 12'($urandom_range(1, 4095)); enable = 1'b1;
    repeat (r) @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({DA3162_CH1, DA3162_CH2} !== 24'd0 || {busy, underflow, s_ready} !== 3'b000) begin
      fails++;
      $display("FAIL reset_run out=%h flags=%b exp 0/000", {DA3162_CH1, DA3162_CH2}, {busy, underflow, s_ready});
    end
    @(negedge clk_in);
    rst = 1'b0; enable = 1'b0;
    @(negedge clk_in);
    tests++;
    if ({DA3162_CH1, DA3162_CH2} !== 24'd0 || busy !== 1'b0) begin fails++; $display("FAIL reset_after out=%h busy=%b exp 0/0", {DA3162_CH1, DA3162_CH2}, busy); end
  endtask

  initial begin
    test_reset;
    test_dc;
    test_ramp(12'h400, 10);
    test_ramp(12'($urandom), 24);
    test_square(16'd3, 14);
    test_square(16'd0, 8);
    test_square(16'($urandom_range(1, 6)), 20);
    test_stream(80);
    test_stream(50);
    test_reset_run;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
